fsm_state_register: RTL and testbench
=====================================

Name: fsm_state_register

Overview:
- Downstream partner of the state-transition-function stage (stateTransFn_beh).
- Each `in_valid` cycle it registers the 2-bit `nextstate` into `currstate` and feeds `currstate` back to the transition function.
- It also generates a one-cycle `detect` pulse on every entry into the accepting state, and keeps a saturating count of detections.
- Together with the transition stage it forms the complete serial sequence-detector datapath.

Parameters:
- RESET_STATE, 2'b00, state code loaded by reset and by `clr`.
- ACCEPT_STATE, 2'b11, state code that counts as a detection.
- CNT_W, 8, width of the detection counter (range 2..16).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  `nextstate` is valid this cycle; the register updates only when this is high.
- nextstate  input  2  next-state code from the transition-function stage.
- clr  input  1  synchronous clear: restarts the FSM and zeroes the statistics.
- currstate  output  2  registered current state; fed back to the transition function.
- prevstate  output  2  state held before the most recent update.
- detect  output  1  one-cycle pulse: ACCEPT_STATE was entered on the previous edge.
- det_count  output  CNT_W  number of detections since reset/clr, saturating.
- count_sat  output  1  sticky flag: det_count reached its maximum.

Behaviour:
- Reset is asynchronous and active-low, using one clock. While rst_n=0:
  - currstate=RESET_STATE, prevstate=RESET_STATE
  - detect=0, det_count=0, count_sat=0
- Reset release is synchronous to clk (first update on the first rising edge with rst_n=1).
- All outputs are registered; there is no combinational path from inputs to outputs.
- Priority at each rising edge: clr > in_valid > hold.
- clr=1 (regardless of in_valid):
  - currstate<=RESET_STATE, prevstate<=RESET_STATE
  - det_count<=0, count_sat<=0, detect<=0
- clr=0, in_valid=1:
  - prevstate<=currstate; currstate<=nextstate.
  - If nextstate==ACCEPT_STATE: detect<=1 and det_count increments.
  - Increment rule: det_count<=det_count+1 unless it equals 2^CNT_W-1, in which case it holds.
  - count_sat<=1 when the post-increment value equals 2^CNT_W-1.
- clr=0, in_valid=0: currstate, prevstate, det_count and count_sat hold; detect<=0.
- Detection latency: `detect` is high in the cycle after the accepting update edge, exactly coincident with currstate==ACCEPT_STATE.
- A self-loop in ACCEPT_STATE with in_valid held high pulses `detect` every cycle; each loop is counted as a new detection (overlapping-pattern semantics).
- Saturation: det_count never wraps. count_sat stays at 1 until reset or clr. `detect` still pulses while saturated.
- Every 2-bit code is legal; no illegal-state recovery is needed. currstate always equals the last accepted nextstate.
- Reset asserted mid-operation clears everything immediately, independent of clk; no detect pulse is generated on reset release.
- An in_valid gap does not break a pattern; the FSM simply stalls.

Test Plan:
- Reset: rst_n=0 for 3 cycles, with the nextstate/in_valid/clr inputs all driven to toggle -> currstate=00, prevstate=00, detect=0, det_count=0, count_sat=0 throughout; first edge after release with in_valid=1, nextstate=01 -> currstate=01, prevstate=00.
- Sequence 00->01->10->11 with in_valid=1 each cycle -> currstate follows one cycle later; detect=1 only in the cycle currstate=11; det_count=1.
- Stall: same sequence with in_valid=0 cycles inserted before 11 -> currstate holds during gaps, detect=0 in gaps, single detect pulse, det_count=1.
- Self-loop: nextstate=11 with in_valid=1 for 4 cycles -> detect high 4 consecutive cycles, det_count=4.
- Saturation with CNT_W=2: 5 accepting updates -> det_count 1,2,3,3,3; count_sat=1 from the 3rd detect onward; detect still pulses on 4th and 5th.
- clr priority: in_valid=1, nextstate=11, clr=1 on the same edge -> currstate=00, det_count=0, detect=0, count_sat=0. Then assert rst_n=0 mid-sequence between edges -> outputs clear immediately.

Source files
------------

// File: rtl/fsm_state_register.sv
// Purpose : current-state register of the serial sequence detector, with a detect pulse and a saturating detection count.
// Latency : one cycle; every output is registered and changes only on a rising edge (or on async reset).
// Backpres: none; an update happens only when in_valid is high, otherwise the state stalls and no result is lost.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   in_valid   nextstate is valid this cycle
//   nextstate  next-state code from the transition-function stage
//   clr        synchronous clear of the state and the statistics (wins over in_valid)
//   currstate  registered current state, fed back to the transition function
//   prevstate  state held before the most recent update
//   detect     one-cycle pulse, high while currstate has just become ACCEPT_STATE
//   det_count  saturating number of detections since reset/clr
//   count_sat  sticky flag: det_count has reached its maximum
module fsm_state_register #(
    parameter logic [1:0] RESET_STATE  = 2'b00,
    parameter logic [1:0] ACCEPT_STATE = 2'b11,
    parameter int         CNT_W        = 8      // meaningful range 2..16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       nextstate,
    input  logic             clr,
    output logic [1:0]       currstate,
    output logic [1:0]       prevstate,
    output logic             detect,
    output logic [CNT_W-1:0] det_count,
    output logic             count_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // An accepted update that lands in the accepting state is a detection.
    // Self-loops in ACCEPT_STATE count again on every valid cycle.
    logic             accept;
    logic [CNT_W-1:0] cnt_next;

    assign accept = in_valid && (nextstate == ACCEPT_STATE);

    // Saturating increment: the counter parks at its maximum instead of wrapping.
    always_comb begin
        cnt_next = det_count;
        if (det_count != CNT_MAX) begin
            cnt_next = det_count + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            currstate <= RESET_STATE;
            prevstate <= RESET_STATE;
            detect    <= 1'b0;
            det_count <= '0;
            count_sat <= 1'b0;
        end else if (clr) begin
            currstate <= RESET_STATE;
            prevstate <= RESET_STATE;
            detect    <= 1'b0;
            det_count <= '0;
            count_sat <= 1'b0;
        end else if (in_valid) begin
            prevstate <= currstate;
            currstate <= nextstate;
            detect    <= accept;
            if (accept) begin
                det_count <= cnt_next;
                // Sticky: once set, only reset or clr drops it.
                if (cnt_next == CNT_MAX) begin
                    count_sat <= 1'b1;
                end
            end
        end else begin
            // Stall: state and statistics hold, the pulse ends.
            detect <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fsm_state_register.sv
module tb_fsm_state_register;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] nextstate;
    logic       clr;

    // Wide counter instance and a 2-bit counter instance share all inputs.
    logic [1:0] cur8, prv8, cur2, prv2;
    logic       det8, det2, sat8, sat2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    fsm_state_register #(.RESET_STATE(2'b00), .ACCEPT_STATE(2'b11), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .nextstate(nextstate), .clr(clr),
        .currstate(cur8), .prevstate(prv8), .detect(det8), .det_count(cnt8), .count_sat(sat8)
    );

    fsm_state_register #(.RESET_STATE(2'b00), .ACCEPT_STATE(2'b11), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .nextstate(nextstate), .clr(clr),
        .currstate(cur2), .prevstate(prv2), .detect(det2), .det_count(cnt2), .count_sat(sat2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: outputs seen at a negedge belong to edge number cyc.
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int         cyc;
        logic [1:0] cur;
        logic [1:0] prv;
        logic       det;
        logic [7:0] c8;
        logic [1:0] c2;
        logic       s8;
        logic       s2;
    } exp_t;

    exp_t q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t edge %0d: got %0h expected %0h", nm, $time, cyc, act, exp);
        end
    endtask

    // Monitor: pops every expectation due at the current edge and compares.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cyc) begin
                chk("stale_expectation", 16'(e.cyc), 16'(cyc));
            end else begin
                chk("currstate8", 16'(cur8), 16'(e.cur));
                chk("prevstate8", 16'(prv8), 16'(e.prv));
                chk("detect8",    16'(det8), 16'(e.det));
                chk("det_count8", 16'(cnt8), 16'(e.c8));
                chk("count_sat8", 16'(sat8), 16'(e.s8));
                chk("currstate2", 16'(cur2), 16'(e.cur));
                chk("prevstate2", 16'(prv2), 16'(e.prv));
                chk("detect2",    16'(det2), 16'(e.det));
                chk("det_count2", 16'(cnt2), 16'(e.c2));
                chk("count_sat2", 16'(sat2), 16'(e.s2));
            end
        end
    end

    // Reference model: list of accepted states since the last reset/clr,
    // plus the plain number of accepting updates in that window.
    logic [1:0] acc[$];
    int         n_acc = 0;

    function automatic exp_t model_view(input int target, input logic det);
        exp_t e;
        e.cyc = target;
        e.cur = (acc.size() > 0) ? acc[acc.size()-1] : 2'b00;
        e.prv = (acc.size() > 1) ? acc[acc.size()-2] : 2'b00;
        e.det = det;
        e.c8  = (n_acc > 255) ? 8'd255 : 8'(n_acc);
        e.c2  = (n_acc > 3)   ? 2'd3   : 2'(n_acc);
        e.s8  = (n_acc >= 255);
        e.s2  = (n_acc >= 3);
        return e;
    endfunction

    // Drive one cycle of inputs, predict the outputs after the coming edge.
    task automatic apply(input logic r, input logic v, input logic [1:0] ns, input logic c);
        logic det;
        rst_n     = r;
        in_valid  = v;
        nextstate = ns;
        clr       = c;
        det       = 1'b0;
        if (!r || c) begin
            acc.delete();
            n_acc = 0;
        end else if (v) begin
            acc.push_back(ns);
            if (acc.size() > 2) void'(acc.pop_front());
            if (ns == 2'b11) begin
                n_acc++;
                det = 1'b1;
            end
        end
        q.push_back(model_view(cyc + 1, det));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; nextstate = 2'b00; clr = 1'b0;
        #1;

        // Reset held for 3 edges while the other inputs toggle.
        for (int k = 1; k <= 3; k++) begin
            apply(1'b0, k[0], 2'(k * 3), k == 2);
        end

        // Plain sequence 01 -> 10 -> 11.
        apply(1, 1, 2'b01, 0);
        apply(1, 1, 2'b10, 0);
        apply(1, 1, 2'b11, 0);
        apply(1, 1, 2'b00, 0);

        // Stall gaps before the accepting update.
        apply(1, 0, 2'b11, 1);
        apply(1, 1, 2'b01, 0);
        apply(1, 0, 2'b11, 0);
        apply(1, 1, 2'b10, 0);
        apply(1, 0, 2'b11, 0);
        apply(1, 0, 2'b01, 0);
        apply(1, 1, 2'b11, 0);
        apply(1, 0, 2'b10, 0);

        // Self-loop in the accepting state: the 2-bit counter saturates at the 3rd.
        apply(1, 0, 2'b00, 1);
        for (int k = 0; k < 4; k++) apply(1, 1, 2'b11, 0);
        apply(1, 1, 2'b00, 0);

        // Five separated accepting updates: 2-bit counts 1,2,3,3,3.
        apply(1, 0, 2'b00, 1);
        for (int k = 0; k < 5; k++) begin
            apply(1, 1, 2'b11, 0);
            apply(1, 1, 2'(k % 3), 0);
        end

        // clr wins over an accepting update on the same edge.
        apply(1, 1, 2'b11, 1);
        apply(1, 0, 2'b10, 0);

        // Drive the 8-bit counter into saturation and beyond.
        for (int k = 0; k < 260; k++) apply(1, 1, 2'b11, 0);
        apply(1, 1, 2'b01, 0);
        apply(1, 1, 2'b11, 0);

        // Randomised traffic with occasional clears.
        for (int k = 0; k < 400; k++) begin
            apply(1, ($urandom_range(3) != 0), 2'($urandom_range(3)), ($urandom_range(39) == 0));
        end

        // Build up some non-reset state, then reset asynchronously between edges.
        apply(1, 1, 2'b10, 0);
        apply(1, 1, 2'b11, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        acc.delete();
        n_acc = 0;
        #1;
        chk("async_rst_currstate", 16'(cur8), 16'h0);
        chk("async_rst_prevstate", 16'(prv8), 16'h0);
        chk("async_rst_detect",    16'(det8), 16'h0);
        chk("async_rst_count",     16'(cnt8), 16'h0);
        chk("async_rst_sat2",      16'(sat2), 16'h0);
        chk("async_rst_count2",    16'(cnt2), 16'h0);
        apply(0, 1, 2'b11, 0);
        apply(0, 1, 2'b11, 0);
        // Release: no pulse on release, first edge loads nextstate.
        apply(1, 1, 2'b01, 0);
        apply(1, 1, 2'b11, 0);
        apply(1, 0, 2'b00, 0);

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            chk("drain_pending", 16'(q.size()), 16'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
